// File: rtl/pio_servo_pkg.sv
// pio_servo_pkg: command/status field positions, width type and clamp helper for the PIO servo block
// No ports; imported by pio_servo_timebase and pio_servo_cmd.
package pio_servo_pkg;
    typedef logic [15:0] width_t;
    localparam int CMD_TOG    = 31;
    localparam int CMD_CH_MSB = 27;
    localparam int CMD_CH_LSB = 24;
    localparam int CMD_W_MSB  = 15;
    localparam int CMD_W_LSB  = 0;
    localparam int ST_TOG     = 31;
    localparam int ST_ERR     = 30;
    localparam int ST_CLAMP   = 29;
    localparam int ST_CH_LSB  = 24;
    localparam int ST_FC_LSB  = 16;
    localparam int ST_W_LSB   = 0;
    function automatic width_t clamp_width(input width_t w, input width_t lo, input width_t hi);
        return (w < lo) ? lo : (w > hi) ? hi : w;
    endfunction
endpackage

// File: rtl/pio_servo_cmd_if.sv
// pio_servo_cmd_if: PIO command/status word pair between software port and servo block
// cmd_word: command from PIO out_port; status_word: status to PIO in_port.
interface pio_servo_cmd_if;
    logic [31:0] cmd_word;
    logic [31:0] status_word;
    modport master (output cmd_word, input status_word);
    modport slave (input cmd_word, output status_word);
endinterface

// File: rtl/pio_servo_timebase.sv
// pio_servo_timebase: 1 us prescaler, microsecond frame counter, wrap and frame_start pulse
// Ports: clk, reset (sync, active-high); o_us_cnt microsecond position in frame;
// o_wrap combinational, high on the last tick of a frame; o_frame_start registered pulse with us_cnt == 0.
module pio_servo_timebase
    import pio_servo_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int FRAME_US    = 20000
) (
    input  logic   clk,
    input  logic   reset,
    output width_t o_us_cnt,
    output logic   o_wrap,
    output logic   o_frame_start
);
    localparam int DIV = CLK_FREQ_HZ / 1000000;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    logic [PW-1:0] r_pre;
    width_t        r_us;
    logic          r_fs;
    logic          w_tick;
    assign w_tick        = r_pre == PW'(DIV - 1);
    assign o_wrap        = w_tick && (r_us == width_t'(FRAME_US - 1));
    assign o_us_cnt      = r_us;
    assign o_frame_start = r_fs;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pre <= '0;
            r_us  <= '0;
            r_fs  <= 1'b0;
        end else begin
            r_pre <= w_tick ? '0 : r_pre + 1'b1;
            r_us  <= o_wrap ? '0 : w_tick ? r_us + 16'd1 : r_us;
            r_fs  <= o_wrap;
        end
    end
endmodule

// File: rtl/pio_servo_cmd.sv
// pio_servo_cmd: toggle-handshake PIO command decoder driving NUM_CH shadowed hobby-servo PWM outputs
// Ports: clk, reset (sync, active-high); pio.cmd_word in / pio.status_word out (registered fields);
// o_pwm_out registered servo pulses; o_frame_start one-cycle pulse at each frame start.
module pio_servo_cmd
    import pio_servo_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int NUM_CH      = 4,
    parameter int FRAME_US    = 20000,
    parameter int MIN_US      = 500,
    parameter int MAX_US      = 2500,
    parameter int DEFAULT_US  = 1500
) (
    input  logic              clk,
    input  logic              reset,
    pio_servo_cmd_if.slave    pio,
    output logic [NUM_CH-1:0] o_pwm_out,
    output logic              o_frame_start
);
    logic              r_tog;
    logic              r_err;
    logic              r_clamp;
    logic [3:0]        r_ch;
    logic [7:0]        r_fc;
    width_t            r_w;
    width_t            r_pend [NUM_CH];
    width_t            r_act  [NUM_CH];
    logic [NUM_CH-1:0] r_pwm;
    width_t            w_us;
    logic              w_wrap;
    logic              w_acc;
    logic              w_ok;
    logic [3:0]        w_ch;
    width_t            w_raw;
    width_t            w_cw;
    logic              w_unused;
    pio_servo_timebase #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ),
        .FRAME_US   (FRAME_US)
    ) u_tb (
        .clk          (clk),
        .reset        (reset),
        .o_us_cnt     (w_us),
        .o_wrap       (w_wrap),
        .o_frame_start(o_frame_start)
    );
    // A differing toggle bit is a new command; taking it into r_tog stops re-sampling.
    assign w_acc    = pio.cmd_word[CMD_TOG] != r_tog;
    assign w_ch     = pio.cmd_word[CMD_CH_MSB:CMD_CH_LSB];
    assign w_raw    = pio.cmd_word[CMD_W_MSB:CMD_W_LSB];
    assign w_cw     = clamp_width(w_raw, width_t'(MIN_US), width_t'(MAX_US));
    assign w_ok     = 5'(w_ch) < 5'(NUM_CH);
    assign w_unused = ^{pio.cmd_word[30:28], pio.cmd_word[23:16]};
    assign o_pwm_out = r_pwm;
    always_comb begin
        pio.status_word                       = '0;
        pio.status_word[ST_TOG]               = r_tog;
        pio.status_word[ST_ERR]               = r_err;
        pio.status_word[ST_CLAMP]             = r_clamp;
        pio.status_word[ST_CH_LSB +: 4]       = r_ch;
        pio.status_word[ST_FC_LSB +: 8]       = r_fc;
        pio.status_word[ST_W_LSB +: 16]       = r_w;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tog   <= 1'b0;
            r_err   <= 1'b0;
            r_clamp <= 1'b0;
            r_ch    <= '0;
            r_fc    <= '0;
            r_w     <= '0;
            r_pwm   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_pend[i] <= width_t'(DEFAULT_US);
                r_act[i]  <= width_t'(DEFAULT_US);
            end
        end else begin
            if (w_acc) begin
                r_tog   <= pio.cmd_word[CMD_TOG];
                r_err   <= !w_ok;
                r_clamp <= w_cw != w_raw;
                r_ch    <= w_ch;
                r_w     <= w_cw;
            end
            if (w_wrap)
                r_fc <= r_fc + 8'd1;
            // Active loads the pre-edge pending value, so a command in the wrap cycle waits a frame.
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_acc && w_ok && w_ch == 4'(i))
                    r_pend[i] <= w_cw;
                if (w_wrap)
                    r_act[i] <= r_pend[i];
                r_pwm[i] <= w_us < r_act[i];
            end
        end
    end
endmodule

// File: tb/tb_pio_servo_cmd.sv
// tb_pio_servo_cmd: directed checks of command acceptance, clamping, shadowing, frame timing and reset
module tb_pio_servo_cmd;
    localparam int CLK  = 2000000;
    localparam int NCH  = 4;
    localparam int FUS  = 1000;
    localparam int MINU = 100;
    localparam int MAXU = 800;
    localparam int DEFU = 300;
    localparam int FC   = FUS * (CLK / 1000000);
    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [NCH-1:0] pwm;
    logic           fs;
    int             n_run = 0;
    int             n_fail = 0;
    int             hi [NCH];
    logic [31:0]    st_b;
    logic [31:0]    st_a;
    pio_servo_cmd_if pio ();
    pio_servo_cmd #(
        .CLK_FREQ_HZ(CLK),
        .NUM_CH     (NCH),
        .FRAME_US   (FUS),
        .MIN_US     (MINU),
        .MAX_US     (MAXU),
        .DEFAULT_US (DEFU)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pio          (pio),
        .o_pwm_out    (pwm),
        .o_frame_start(fs)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask
    task automatic chk_w(input string tag, input int e0, input int e1, input int e2, input int e3);
        int e [NCH];
        e = '{e0, e1, e2, e3};
        for (int ch = 0; ch < NCH; ch++)
            chk($sformatf("%s_ch%0d", tag, ch), 32'(hi[ch]), 32'(e[ch]));
    endtask
    // Called on the negedge where frame_start is high; measures one whole frame,
    // optionally driving cmd c at sample inj and capturing status before/after it.
    task automatic frame(input int inj, input logic [31:0] c);
        int extra;
        extra = 0;
        chk("frame_start", 32'(fs), 32'd1);
        for (int ch = 0; ch < NCH; ch++) hi[ch] = 0;
        for (int j = 0; j < FC; j++) begin
            if (j == inj + 1) st_a = pio.status_word;
            if (j > 0 && fs) extra++;
            for (int ch = 0; ch < NCH; ch++) hi[ch] += int'(pwm[ch]);
            if (j == inj) begin
                st_b = pio.status_word;
                pio.cmd_word = c;
            end
            @(negedge clk);
        end
        if (inj == FC - 1) st_a = pio.status_word;
        chk("fs_extra", 32'(extra), 32'd0);
    endtask
    // Called on a negedge with reset high; releases reset and measures the first frame.
    task automatic boot();
        int c;
        chk("rst_status", pio.status_word, 32'd0);
        chk("rst_pwm", 32'(pwm), 32'd0);
        chk("rst_fs", 32'(fs), 32'd0);
        for (int ch = 0; ch < NCH; ch++) hi[ch] = 0;
        reset = 1'b0;
        c = 0;
        do begin
            @(negedge clk);
            c++;
            if (c == 1) chk("first_pwm", 32'(pwm), 32'hF);
            for (int ch = 0; ch < NCH; ch++) hi[ch] += int'(pwm[ch]);
        end while (!fs && c < 3 * FC);
        chk("first_fs_cyc", 32'(c), 32'(FC));
        chk_w("boot", 600, 600, 600, 600);
        chk("boot_status", pio.status_word, 32'h0001_0000);
    endtask
    initial begin
        pio.cmd_word = 32'd0;
        repeat (3) @(negedge clk);
        boot();
        frame(100, 32'h8100_01F4);
        chk("t2_before", st_b, 32'h0001_0000);
        chk("t2_ack", st_a, 32'h8101_01F4);
        chk_w("f1", 600, 600, 600, 600);
        frame(50, 32'h0000_0032);
        chk("t3_ack", st_a, 32'h2002_0064);
        chk_w("f2", 600, 1000, 600, 600);
        frame(10, 32'h8200_0384);
        chk("thi_ack", st_a, 32'hA203_0320);
        chk_w("f3", 200, 1000, 600, 600);
        frame(10, 32'h0500_0100);
        chk("t4_togerr", {30'd0, st_a[31:30]}, 32'd1);
        chk_w("f4", 200, 1000, 1600, 600);
        frame(FC - 1, 32'h8300_00C8);
        chk("t5_ack", st_a, 32'h8306_00C8);
        chk_w("f5", 200, 1000, 1600, 600);
        frame(-1, 32'd0);
        chk_w("f6", 200, 1000, 1600, 600);
        frame(-1, 32'd0);
        chk_w("f7", 200, 1000, 1600, 400);
        chk("f8_status", pio.status_word, 32'h8308_00C8);
        repeat (200) @(negedge clk);
        chk("t6_mid", 32'(pwm[1]), 32'd1);
        reset = 1'b1;
        pio.cmd_word = 32'd0;
        @(negedge clk);
        chk("t6_pwm_off", 32'(pwm), 32'd0);
        @(negedge clk);
        boot();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/pio_servo_cmd.md
Name: pio_servo_cmd

Overview:
- Sits directly downstream of the Nios II software PIO output port.
- Consumes the 32-bit PIO command word and turns software-issued commands into glitch-free hobby-servo PWM on NUM_CH channels (matador arm and pan/tilt).
- Returns a registered status word for the PIO input port so software can confirm that each command was accepted.
- Commands use a toggle handshake, so software needs no strobe register.

Parameters:
- CLK_FREQ_HZ, 50000000, system clock frequency; must be an integer multiple of 1 MHz.
- NUM_CH, 4, number of servo channels, 1..16.
- FRAME_US, 20000, PWM frame period in microseconds.
- MIN_US, 500, minimum pulse width after clamping.
- MAX_US, 2500, maximum pulse width after clamping; must be less than FRAME_US.
- DEFAULT_US, 1500, pulse width loaded at reset (servo centre).

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- cmd_word  in  32  command word from the PIO out_port.
- status_word  out  32  status word to the PIO in_port.
- pwm_out  out  NUM_CH  servo pulse outputs, registered.
- frame_start  out  1  one-cycle pulse at the start of each frame.

Behaviour:
- Command fields in cmd_word:
  - [31] = toggle
  - [27:24] = channel
  - [15:0] = width_us (unsigned)
  - all other bits are ignored.
- Acceptance:
  - The block holds a register tog_q.
  - A command is accepted in any cycle where cmd_word[31] != tog_q; tog_q takes cmd_word[31] in that same cycle.
  - At most one command is accepted per toggle edge; cmd_word is not re-sampled until the next toggle.
- Channel check:
  - If channel >= NUM_CH, the command is acknowledged (tog_q updates) but discarded, and err_chan is set.
  - Otherwise err_chan is cleared.
- Clamping:
  - width = max(MIN_US, min(MAX_US, width_us)), computed in 16 bits.
  - clamped = 1 if the value changed, else 0.
- Shadow registers:
  - An accepted command writes pending[ch].
  - active[i] loads pending[i] only at a frame wrap.
  - A command accepted in the wrap cycle itself goes to pending and takes effect in the following frame. There is no bypass.
- Timebase:
  - A prescaler counts 0..CLK_FREQ_HZ/1e6-1 and emits a 1-cycle tick on its terminal count.
  - us_cnt advances on each tick, 0..FRAME_US-1, then wraps to 0.
  - A wrap is the tick with us_cnt == FRAME_US-1.
  - frame_start pulses in the cycle after a wrap, aligned with us_cnt == 0.
- PWM output:
  - pwm_out[i] <= (us_cnt < active[i]), registered, giving 1 cycle of latency from the counter.
  - The pulse length is exactly active[i] microseconds, accurate to ±0 clocks.
- status_word (registered):
  - [31] = tog_q, the ack toggle.
  - [30] = err_chan.
  - [29] = clamped.
  - [27:24] = last accepted channel.
  - [23:16] = frame counter, 8 bits, wraps at 255→0, increments on each wrap.
  - [15:0] = last accepted clamped width.
  - All other bits are 0.
  - The ack becomes visible 1 cycle after the toggle edge on cmd_word.
- Reset (including reset mid-frame or mid-pulse):
  - pwm_out = 0, frame_start = 0, status_word = 0.
  - tog_q = 0; prescaler and us_cnt = 0; frame counter = 0.
  - pending[] and active[] = DEFAULT_US.
  - First cycle after reset: us_cnt = 0 and active = DEFAULT_US; pulses start without a frame_start pulse.
  - If cmd_word[31] = 1 while reset deasserts, that command is accepted in the first cycle after reset. This is intended; the PIO resets its port to 0.
- Simultaneous events:
  - A command accept and a wrap in the same cycle are independent.
  - The frame counter and active load happen normally.
  - status updates from the command take priority only for their own fields.

Decomposition:
- Package pio_servo_pkg:
  - cmd field LSB/MSB constants
  - status bit positions
  - 16-bit width type
  - function clamp_width.
- Sub-module pio_servo_timebase: prescaler, us_cnt, wrap and frame_start generation.
- Parent module: command decode, pending/active registers, per-channel comparators and status.

Test Plan:
1. Reset with cmd_word = 0 → pwm_out[0] high for 1500 us (75000 clk) each 20 ms frame; status_word = 0; first frame_start at cycle 1,000,000 after reset.
2. cmd_word = 0x8100_07D0 (toggle 1, ch1, 2000) → status_word = 0x8100_07D0 one cycle later. The ch1 pulse stays 1500 us for the rest of the current frame and is 2000 us from the next frame_start.
3. cmd_word = 0x0000_0064 (toggle 0, ch0, 100) → width clamped to 500; status[29] = 1; status[15:0] = 0x01F4; ch0 pulse = 25000 clk next frame.
4. cmd_word = 0x8500_0400 with NUM_CH = 4 (ch5) → status[31] = 1, status[30] = 1; all pulse widths unchanged.
5. Toggle arrives in the same cycle as the wrap (us_cnt = 19999, last tick) → width unchanged in the starting frame, new width in the frame after; frame counter increments by exactly 1.
6. Assert reset 500 us into a 2000 us ch1 pulse → pwm_out = 0 the cycle after reset; after release ch1 = 1500 us (DEFAULT_US) and status_word = 0.
